// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the data-memory responder:
//   - state_e       : responder FSM encoding (IDLE / WAIT / RESP; 2'd3 unused)
//   - WORD_BYTES    : bytes per memory word
//   - BE_W          : byte-enable width
//   - addr_in_range : unsigned window check of a byte address against a region
// -----------------------------------------------------------------------------
package mem_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_e;

   localparam int WORD_BYTES = 4;
   localparam int BE_W       = 4;

   // True when addr lies inside [base, base + depth*WORD_BYTES). The offset is
   // taken modulo 2^32, so an address below base wraps to a huge offset and
   // is reported as out of range.
   function automatic logic addr_in_range(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input logic [31:0] depth);
      logic [31:0] offset;
      offset = addr - base;
      return (offset < (depth * 32'(WORD_BYTES)));
   endfunction

endpackage

// File: rtl/mem_array.sv
// -----------------------------------------------------------------------------
// mem_array
// DEPTH_WORDS x 32-bit single-port RAM with per-byte write enables and a
// registered read port. Contents are not reset.
// Ports:
//   clk    in   rising-edge clock
//   en     in   access strobe; nothing happens while low
//   we     in   1 = write selected byte lanes, 0 = read full word
//   be     in   byte enables, bit i -> lane [8i+7:8i]
//   addr   in   word index
//   wdata  in   write data
//   rdata  out  read data, updated only by an enabled read
// -----------------------------------------------------------------------------
module mem_array
   import mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = $clog2(DEPTH_WORDS)
) (
   input  logic            clk,
   input  logic            en,
   input  logic            we,
   input  logic [BE_W-1:0] be,
   input  logic [AW-1:0]   addr,
   input  logic [31:0]     wdata,
   output logic [31:0]     rdata
);

   logic [31:0] mem_q [DEPTH_WORDS];
   logic [31:0] rdata_q;

   // Storage port: byte-lane write or full-word read into the output register.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int i = 0; i < BE_W; i++) begin
               if (be[i]) begin
                  mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
               end
            end
         end else begin
            rdata_q <= mem_q[addr];
         end
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Target end of the CPU load/store port. Accepts one request at a time,
// inserts WAIT_CYCLES wait states, performs a byte-lane write or a full-word
// read on the local RAM and returns read data plus an error flag.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   req_valid  in   request present (held stable until accepted)
//   req_ready  out  responder can accept a request (registered)
//   req_we     in   1 = write, 0 = read
//   req_addr   in   byte address
//   req_wdata  in   write data
//   req_be     in   byte enables
//   rsp_valid  out  response present (registered)
//   rsp_ready  in   initiator accepts response
//   rsp_rdata  out  read data; 0 for writes and errors
//   rsp_err    out  misaligned or out-of-range access (registered)
// -----------------------------------------------------------------------------
module mem_responder
   import mem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_we,
   input  logic [31:0]     req_addr,
   input  logic [31:0]     req_wdata,
   input  logic [BE_W-1:0] req_be,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [31:0]     rsp_rdata,
   output logic            rsp_err
);

   localparam int         AW        = $clog2(DEPTH_WORDS);
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   state_e          state_q,     state_d;
   logic [3:0]      cnt_q,       cnt_d;
   logic            req_ready_q, req_ready_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic            rsp_err_q,   rsp_err_d;
   logic            rd_ok_q,     rd_ok_d;
   logic            lat_we_q,    lat_we_d;
   logic [31:0]     lat_addr_q,  lat_addr_d;
   logic [31:0]     lat_wdata_q, lat_wdata_d;
   logic [BE_W-1:0] lat_be_q,    lat_be_d;

   logic [31:0]     offset_s;
   logic [AW-1:0]   word_idx_s;
   logic            err_s;
   logic            commit_s;
   logic            mem_en_s;
   logic [31:0]     mem_rdata_s;

   // Decode of the latched request; stable for the whole WAIT phase.
   always_comb begin
      offset_s   = lat_addr_q - BASE_ADDR;
      word_idx_s = AW'(offset_s >> 2);
      err_s      = (lat_addr_q[1:0] != 2'b00) ||
                   !addr_in_range(lat_addr_q, BASE_ADDR, 32'(DEPTH_WORDS));
      commit_s   = (state_q == S_WAIT) && (cnt_q == 4'd0);
      mem_en_s   = commit_s && !err_s;
   end

   // Next-state logic for the FSM, wait counter, request latches and response flags.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rsp_err_d   = rsp_err_q;
      rd_ok_d     = rd_ok_q;
      lat_we_d    = lat_we_q;
      lat_addr_d  = lat_addr_q;
      lat_wdata_d = lat_wdata_q;
      lat_be_d    = lat_be_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid && req_ready_q) begin
               lat_we_d    = req_we;
               lat_addr_d  = req_addr;
               lat_wdata_d = req_wdata;
               lat_be_d    = req_be;
               cnt_d       = WAIT_INIT;
               state_d     = S_WAIT;
            end else begin
               state_d     = S_IDLE;
            end
         end
         S_WAIT: begin
            if (cnt_q != 4'd0) begin
               cnt_d   = cnt_q - 4'd1;
            end else begin
               // Commit edge: RAM access happens now, response fields latch now.
               rsp_err_d = err_s;
               rd_ok_d   = !lat_we_q && !err_s;
               state_d   = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_RESP;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      // Handshake outputs are registered copies of the next state.
      req_ready_d = (state_d == S_IDLE);
      rsp_valid_d = (state_d == S_RESP);
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= 4'd0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rd_ok_q     <= 1'b0;
         lat_we_q    <= 1'b0;
         lat_addr_q  <= 32'd0;
         lat_wdata_q <= 32'd0;
         lat_be_q    <= {BE_W{1'b0}};
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rd_ok_q     <= rd_ok_d;
         lat_we_q    <= lat_we_d;
         lat_addr_q  <= lat_addr_d;
         lat_wdata_q <= lat_wdata_d;
         lat_be_q    <= lat_be_d;
      end
   end

   mem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_mem_array (
      .clk   (clk),
      .en    (mem_en_s),
      .we    (lat_we_q),
      .be    (lat_be_q),
      .addr  (word_idx_s),
      .wdata (lat_wdata_q),
      .rdata (mem_rdata_s)
   );

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   // The RAM output register holds the word read at the commit edge; rd_ok_q
   // (same edge) forces zero for writes, errors and after reset.
   assign rsp_rdata = rd_ok_q ? mem_rdata_s : 32'd0;

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
// Directed bench for mem_responder. Instance A: BASE_ADDR=0, instance B:
// BASE_ADDR=0x1000; both DEPTH_WORDS=1024, WAIT_CYCLES=2. Expected responses
// are queued when a request is driven and compared when rsp_valid rises.
// -----------------------------------------------------------------------------
module tb_mem_responder;

   localparam int LAT = 3;   // accept edge -> rsp_valid, WAIT_CYCLES + 1

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic        a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready, a_rsp_err;
   logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
   logic [3:0]  a_req_be;
   logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_rsp_err;
   logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
   logic [3:0]  b_req_be;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;
   exp_t sb_q[$];

   mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(2)) u_dut_a (
      .clk(clk), .rst(rst),
      .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
      .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_be(a_req_be),
      .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
      .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
   );

   mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_1000), .WAIT_CYCLES(2)) u_dut_b (
      .clk(clk), .rst(rst),
      .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
      .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
      .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
      .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive_req(input bit sel, input logic v, input logic we,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be);
      if (sel) begin
         b_req_valid = v; b_req_we = we; b_req_addr = addr; b_req_wdata = wdata; b_req_be = be;
      end else begin
         a_req_valid = v; a_req_we = we; a_req_addr = addr; a_req_wdata = wdata; a_req_be = be;
      end
   endtask

   task automatic wait_accept(input bit sel, input string tag);
      logic acc;
      logic rdy;
      acc = 1'b0;
      for (int i = 0; i < 20 && !acc; i++) begin
         rdy = sel ? b_req_ready : a_req_ready;
         @(posedge clk); #1;
         if (rdy) acc = 1'b1;
      end
      chk({tag, "_accept"}, {31'd0, acc}, 32'd1);
   endtask

   task automatic wait_rsp(input bit sel, input string tag);
      int   lat;
      exp_t e;
      lat = 0;
      while (!(sel ? b_rsp_valid : a_rsp_valid) && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_lat"}, 32'(lat), 32'(LAT));
      chk({tag, "_sb"}, 32'(sb_q.size()), 32'd1);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk({tag, "_rdata"}, sel ? b_rsp_rdata : a_rsp_rdata, e.rdata);
         chk({tag, "_err"}, {31'd0, sel ? b_rsp_err : a_rsp_err}, {31'd0, e.err});
      end
   endtask

   task automatic ack_rsp(input bit sel, input string tag);
      if (sel) b_rsp_ready = 1'b1; else a_rsp_ready = 1'b1;
      @(posedge clk); #1;
      a_rsp_ready = 1'b0;
      b_rsp_ready = 1'b0;
      chk({tag, "_rsp_drop"}, {31'd0, sel ? b_rsp_valid : a_rsp_valid}, 32'd0);
      chk({tag, "_rdy_back"}, {31'd0, sel ? b_req_ready : a_req_ready}, 32'd1);
   endtask

   task automatic xfer(input bit sel, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input logic [31:0] exp_rdata, input logic exp_err, input string tag);
      exp_t e;
      e.rdata = exp_rdata;
      e.err   = exp_err;
      sb_q.push_back(e);
      drive_req(sel, 1'b1, we, addr, wdata, be);
      wait_accept(sel, tag);
      drive_req(sel, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      wait_rsp(sel, tag);
      ack_rsp(sel, tag);
   endtask

   // Watchdog so a stuck handshake still ends the run.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_t e;
      drive_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      drive_req(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      a_rsp_ready = 1'b0;
      b_rsp_ready = 1'b0;

      // Reset: outputs low while held, req_ready rises on first edge after release.
      repeat (3) @(posedge clk);
      #1;
      chk("rst_a_req_ready", {31'd0, a_req_ready}, 32'd0);
      chk("rst_b_req_ready", {31'd0, b_req_ready}, 32'd0);
      chk("rst_a_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
      chk("rst_a_rsp_rdata", a_rsp_rdata, 32'd0);
      chk("rst_a_rsp_err",   {31'd0, a_rsp_err}, 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rel_a_req_ready", {31'd0, a_req_ready}, 32'd1);
      chk("rel_b_req_ready", {31'd0, b_req_ready}, 32'd1);

      // Full-word write and read back.
      xfer(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'd0,         1'b0, "wr_10");
      xfer(1'b0, 1'b0, 32'h10, 32'd0,         4'hF, 32'hDEAD_BEEF, 1'b0, "rd_10");

      // Byte lanes and the be=0 no-op.
      xfer(1'b0, 1'b1, 32'h20, 32'h1122_3344, 4'hF,    32'd0,         1'b0, "wr_20");
      xfer(1'b0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, 32'd0,         1'b0, "wr_20_be5");
      xfer(1'b0, 1'b0, 32'h20, 32'd0,         4'h0,    32'h11BB_33DD, 1'b0, "rd_20_lanes");
      xfer(1'b0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'h0,    32'd0,         1'b0, "wr_20_be0");
      xfer(1'b0, 1'b0, 32'h20, 32'd0,         4'hF,    32'h11BB_33DD, 1'b0, "rd_20_be0");

      // Errors and the top-of-range boundary on instance A.
      xfer(1'b0, 1'b0, 32'h13,   32'd0,         4'hF, 32'd0,         1'b1, "rd_misalign");
      xfer(1'b0, 1'b1, 32'h0,    32'hCAFE_F00D, 4'hF, 32'd0,         1'b0, "wr_0");
      xfer(1'b0, 1'b1, 32'h1000, 32'h1234_5678, 4'hF, 32'd0,         1'b1, "wr_oor");
      xfer(1'b0, 1'b0, 32'h0,    32'd0,         4'hF, 32'hCAFE_F00D, 1'b0, "rd_0_after_oor");
      xfer(1'b0, 1'b1, 32'hFFC,  32'h0F0F_A5A5, 4'hF, 32'd0,         1'b0, "wr_last");
      xfer(1'b0, 1'b0, 32'hFFC,  32'd0,         4'hF, 32'h0F0F_A5A5, 1'b0, "rd_last");

      // Instance B with BASE_ADDR=0x1000: below-base wrap, in-range, above-range.
      xfer(1'b1, 1'b0, 32'h0FFC, 32'd0,         4'hF, 32'd0,         1'b1, "b_rd_below");
      xfer(1'b1, 1'b1, 32'h1000, 32'h0BAD_F00D, 4'hF, 32'd0,         1'b0, "b_wr_base");
      xfer(1'b1, 1'b0, 32'h1000, 32'd0,         4'hF, 32'h0BAD_F00D, 1'b0, "b_rd_base");
      xfer(1'b1, 1'b0, 32'h2000, 32'd0,         4'hF, 32'd0,         1'b1, "b_rd_above");

      // Backpressure: response held, new request waits until one cycle after handshake.
      e.rdata = 32'hDEAD_BEEF; e.err = 1'b0;
      sb_q.push_back(e);
      drive_req(1'b0, 1'b1, 1'b0, 32'h10, 32'd0, 4'hF);
      wait_accept(1'b0, "bp_rd");
      drive_req(1'b0, 1'b1, 1'b1, 32'h80, 32'h0000_0077, 4'hF);
      wait_rsp(1'b0, "bp_rd");
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("bp_hold_valid", {31'd0, a_rsp_valid}, 32'd1);
         chk("bp_hold_rdata", a_rsp_rdata, 32'hDEAD_BEEF);
         chk("bp_hold_err",   {31'd0, a_rsp_err}, 32'd0);
         chk("bp_hold_ready", {31'd0, a_req_ready}, 32'd0);
      end
      a_rsp_ready = 1'b1;
      @(posedge clk); #1;
      a_rsp_ready = 1'b0;
      chk("bp_hs_valid", {31'd0, a_rsp_valid}, 32'd0);
      chk("bp_hs_ready", {31'd0, a_req_ready}, 32'd1);
      e.rdata = 32'd0; e.err = 1'b0;
      sb_q.push_back(e);
      @(posedge clk); #1;
      chk("bp_next_accepted", {31'd0, a_req_ready}, 32'd0);
      drive_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      wait_rsp(1'b0, "bp_wr");
      ack_rsp(1'b0, "bp_wr");
      xfer(1'b0, 1'b0, 32'h80, 32'd0, 4'hF, 32'h0000_0077, 1'b0, "bp_rd_80");

      // Reset while the write is still in WAIT with cnt=1: write is dropped.
      xfer(1'b0, 1'b1, 32'h40, 32'd0, 4'hF, 32'd0, 1'b0, "wr_40_zero");
      drive_req(1'b0, 1'b1, 1'b1, 32'h40, 32'h0000_0055, 4'hF);
      wait_accept(1'b0, "rw_wr");
      drive_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("rw_in_rst_valid", {31'd0, a_rsp_valid}, 32'd0);
      chk("rw_in_rst_ready", {31'd0, a_req_ready}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk("rw_no_stale_valid", {31'd0, a_rsp_valid}, 32'd0);
      end
      chk("rw_ready_back", {31'd0, a_req_ready}, 32'd1);
      xfer(1'b0, 1'b0, 32'h40, 32'd0, 4'hF, 32'd0, 1'b0, "rw_rd_40");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
